// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting a word-addressed on-chip SRAM window.
// Handles one read or write transaction at a time; out-of-window beats answer SLVERR.
module axi_sram_slave #(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic        s_axi_wlast,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);

  localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        rhit_q, rhit_d;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_word_q;

  logic [31:0]               offset;
  logic                      in_range;
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic [31:0]               addr_next;
  logic                      mem_we;
  logic                      mem_re;
  logic                      unused_size;

  // Unsigned wrap makes addresses below the base land far above the window.
  assign offset    = addr_q - BASE_ADDR;
  assign in_range  = ((offset >> (MEM_WORDS_LOG2 + 2)) == 32'd0);
  assign word_idx  = offset[MEM_WORDS_LOG2+1:2];
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + 32'd4;
  assign unused_size = ^{s_axi_awsize, s_axi_arsize};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    err_d    = err_q;
    wready_d = wready_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rhit_d   = rhit_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axi_awvalid) begin
          addr_d   = s_axi_awaddr;
          cnt_d    = s_axi_awlen;
          burst_d  = s_axi_awburst;
          err_d    = 1'b0;
          wready_d = 1'b1;
          state_d  = WDATA;
        end else if (s_axi_arvalid) begin
          addr_d  = s_axi_araddr;
          cnt_d   = s_axi_arlen;
          burst_d = s_axi_arburst;
          state_d = RFETCH;
        end
      end
      WDATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we = in_range;
          if (!in_range || (s_axi_wlast != (cnt_q == 8'd0))) begin
            err_d = 1'b1;
          end
          if (cnt_q == 8'd0) begin
            wready_d = 1'b0;
            state_d  = WRESP;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = addr_next;
          end
        end
      end
      WRESP: begin
        // Response raised one cycle in so it reflects the error from the final beat.
        if (!bvalid_q) begin
          bvalid_d = 1'b1;
          bresp_d  = err_q ? 2'b10 : 2'b00;
        end else if (s_axi_bready) begin
          bvalid_d = 1'b0;
          bresp_d  = 2'b00;
          state_d  = IDLE;
        end
      end
      RFETCH: begin
        mem_re   = 1'b1;
        rvalid_d = 1'b1;
        rresp_d  = in_range ? 2'b00 : 2'b10;
        rlast_d  = (cnt_q == 8'd0);
        rhit_d   = in_range;
        state_d  = RDATA;
      end
      RDATA: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          rresp_d  = 2'b00;
          rlast_d  = 1'b0;
          rhit_d   = 1'b0;
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_next;
            state_d = RFETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      cnt_q    <= 8'd0;
      burst_q  <= 2'b00;
      err_q    <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
      rhit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rhit_q   <= rhit_d;
    end
  end

  // SRAM array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) mem[word_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
    if (mem_re) rd_word_q <= mem[word_idx];
  end

  assign s_axi_awready = rst_n && (state_q == IDLE);
  assign s_axi_arready = rst_n && (state_q == IDLE) && !s_axi_awvalid;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rhit_q ? rd_word_q : 32'd0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave with a word-array memory model.
module tb_axi_sram_slave;

  localparam int unsigned L2       = 12;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam longint      WIN_BYTES = 4 * (longint'(1) << L2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'b010;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic        s_axi_wlast = 1'b0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'b010;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  axi_sram_slave #(.MEM_WORDS_LOG2(L2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wlast(s_axi_wlast),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [0:(1<<L2)-1];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  bit          ar_pending = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    return (d >= 0) && (d < WIN_BYTES);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd4;
  endfunction

  // Returns 1 when the beat falls outside the window.
  function automatic bit model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!in_win(a)) return 1'b1;
    for (int k = 0; k < 4; k++) if (s[k]) ref_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
    return 1'b0;
  endfunction

  task automatic aw_handshake(input logic [31:0] addr, input int len, input logic [1:0] burst);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    while (!hs && t < 20) begin
      #1; hs = s_axi_awready;
      if (hs && ar_pending) check("both_valid_arready", 64'(s_axi_arready), 64'd0);
      @(posedge clk); #1; t++;
    end
    s_axi_awvalid = 1'b0;
    if (!hs) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (!hs && t < 20) begin
      #1; hs = s_axi_wready;
      @(posedge clk); #1; t++;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    if (!hs) check("w_timeout", 64'd0, 64'd1);
  endtask

  // Latency counts the handshake cycle as cycle 0.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input bit bad_last, input int bdelay, input string tag, output int lat);
    logic [31:0] a;
    bit exp_err;
    bit hs;
    int t;
    a = addr; exp_err = 1'b0;
    aw_handshake(addr, len, burst);
    for (int b = 0; b <= len; b++) begin
      w_beat(wbuf[b], sbuf[b], bad_last ? (b == 0) : (b == len));
      if (model_write(a, wbuf[b], sbuf[b])) exp_err = 1'b1;
      a = next_addr(a, burst);
    end
    if (bad_last && len > 0) exp_err = 1'b1;
    lat = 1; hs = 1'b0; t = 0;
    while (!hs && t < 40) begin
      #1;
      if (s_axi_bvalid) hs = 1'b1;
      else begin @(posedge clk); #1; lat++; t++; end
    end
    if (!hs) begin
      check({tag, "_b_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (ar_pending) check("arready_during_bresp", 64'(s_axi_arready), 64'd0);
    repeat (bdelay) begin @(posedge clk); #1; end
    check({tag, "_bresp"}, 64'(s_axi_bresp), exp_err ? 64'd2 : 64'd0);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check({tag, "_bvalid_drop"}, 64'(s_axi_bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int stall, input string tag, output int lat, output logic [31:0] last_data);
    logic [31:0] a;
    bit hs;
    int t;
    a = addr; lat = 0; last_data = '0; hs = 1'b0; t = 0;
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    while (!hs && t < 60) begin
      #1; hs = s_axi_arready;
      @(posedge clk); #1; t++;
    end
    s_axi_arvalid = 1'b0; ar_pending = 1'b0;
    if (!hs) begin
      check({tag, "_ar_timeout"}, 64'd0, 64'd1);
      return;
    end
    for (int b = 0; b <= len; b++) begin
      int l;
      l = 1; hs = 1'b0; t = 0;
      while (!hs && t < 20) begin
        #1;
        if (s_axi_rvalid) hs = 1'b1;
        else begin @(posedge clk); #1; l++; t++; end
      end
      if (!hs) begin
        check({tag, "_r_timeout"}, 64'd0, 64'd1);
        return;
      end
      if (b == 0) lat = l;
      repeat (stall) begin @(posedge clk); #1; end
      check({tag, "_rdata"}, 64'(s_axi_rdata), in_win(a) ? 64'(ref_mem[widx(a)]) : 64'd0);
      check({tag, "_rresp"}, 64'(s_axi_rresp), in_win(a) ? 64'd0 : 64'd2);
      check({tag, "_rlast"}, 64'(s_axi_rlast), 64'(b == len));
      last_data = s_axi_rdata;
      s_axi_rready = 1'b1;
      @(posedge clk); #1;
      s_axi_rready = 1'b0;
      a = next_addr(a, burst);
    end
  endtask

  function automatic void fill_wbuf();
    for (int j = 0; j < 16; j++) begin wbuf[j] = $urandom; sbuf[j] = 4'hF; end
  endfunction

  initial begin
    int lat;
    logic [31:0] rd;
    logic [31:0] a;
    logic [1:0] bsel [3];
    bit dummy;
    bsel[0] = 2'b00; bsel[1] = 2'b01; bsel[2] = 2'b11;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 64'd0);
    check("rst_data", 64'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'({s_axi_awready, s_axi_arready}), 64'd3);

    // Known contents for the random-traffic region 0x1000..0x13FF.
    for (int i = 0; i < 16; i++) begin
      fill_wbuf();
      axi_write(32'h1000 + 32'(i * 64), 15, 2'b01, 1'b0, 0, "prefill", lat);
    end

    fill_wbuf();
    wbuf[0] = 32'hDEADBEEF;
    axi_write(32'h10, 0, 2'b01, 1'b0, 0, "t1_wr", lat);
    check("t1_wr_latency", 64'(lat), 64'd2);
    axi_read(32'h10, 0, 2'b01, 0, "t1_rd", lat, rd);
    check("t1_rd_latency", 64'(lat), 64'd2);
    check("t1_value", 64'(rd), 64'hDEADBEEF);

    for (int j = 0; j < 16; j++) begin wbuf[j] = 32'(j); sbuf[j] = 4'hF; end
    axi_write(32'h40, 15, 2'b01, 1'b0, 1, "t2_wr", lat);
    axi_read(32'h40, 15, 2'b01, 3, "t2_rd", lat, rd);
    check("t2_final_beat", 64'(rd), 64'd15);

    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    axi_write(32'h80, 0, 2'b01, 1'b0, 0, "t3_wr_a", lat);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    axi_write(32'h80, 0, 2'b01, 1'b0, 0, "t3_wr_b", lat);
    sbuf[0] = 4'hF;
    axi_read(32'h80, 0, 2'b01, 0, "t3_rd", lat, rd);
    check("t3_strb_merge", 64'(rd), 64'h11BB33DD);

    wbuf[0] = 32'hCAFE0000;
    axi_write(32'h0, 0, 2'b01, 1'b0, 0, "t4_wr_base", lat);
    axi_read(32'h4000, 0, 2'b01, 0, "t4_rd_oor", lat, rd);
    check("t4_oor_rdata", 64'(rd), 64'd0);
    wbuf[0] = 32'hBAD0BAD0;
    axi_write(32'h4000, 0, 2'b01, 1'b0, 0, "t4_wr_oor", lat);
    axi_read(32'h0, 0, 2'b01, 0, "t4_rd_base", lat, rd);
    check("t4_mem_unchanged", 64'(rd), 64'hCAFE0000);

    s_axi_araddr = 32'h80; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1; ar_pending = 1'b1;
    wbuf[0] = 32'h5A5A1234;
    axi_write(32'h80, 0, 2'b01, 1'b0, 2, "t5_wr", lat);
    axi_read(32'h80, 0, 2'b01, 0, "t5_rd", lat, rd);
    check("t5_read_after_write", 64'(rd), 64'h5A5A1234);

    fill_wbuf();
    axi_write(32'h3FF8, 3, 2'b01, 1'b0, 0, "t6_edge_wr", lat);
    axi_read(32'h3FF8, 3, 2'b01, 1, "t6_edge_rd", lat, rd);

    fill_wbuf();
    axi_write(32'h100, 3, 2'b00, 1'b0, 0, "t7_fixed_wr", lat);
    axi_read(32'h100, 2, 2'b00, 0, "t7_fixed_rd", lat, rd);
    check("t7_fixed_last_wins", 64'(rd), 64'(wbuf[3]));

    fill_wbuf();
    axi_write(32'h200, 3, 2'b11, 1'b0, 0, "t8_wrap_wr", lat);
    axi_read(32'h200, 3, 2'b01, 0, "t8_wrap_rd", lat, rd);

    fill_wbuf();
    axi_write(32'hFFFF_FFF8, 3, 2'b01, 1'b0, 0, "t9_a32wrap_wr", lat);
    axi_read(32'hFFFF_FFF8, 3, 2'b01, 0, "t9_a32wrap_rd", lat, rd);

    fill_wbuf();
    axi_write(32'h300, 1, 2'b01, 1'b1, 0, "t10_bad_wlast", lat);
    axi_read(32'h300, 1, 2'b01, 0, "t10_rd", lat, rd);

    for (int n = 0; n < 30; n++) begin
      int len;
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 32'h4000 + 32'($urandom_range(0, 1000) * 4);
      else a = 32'h1000 + 32'($urandom_range(0, 240) * 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 16; j++) begin wbuf[j] = $urandom; sbuf[j] = 4'($urandom); end
        axi_write(a, len, bsel[$urandom_range(0, 2)], 1'b0, int'($urandom_range(0, 2)), "rnd_wr", lat);
      end else begin
        axi_read(a, len, bsel[$urandom_range(0, 2)], int'($urandom_range(0, 2)), "rnd_rd", lat, rd);
      end
    end

    // Reset lands while beat 5 of a 16-beat write is being offered.
    fill_wbuf();
    aw_handshake(32'h1000, 15, 2'b01);
    a = 32'h1000;
    for (int b = 0; b < 5; b++) begin
      w_beat(wbuf[b], 4'hF, 1'b0);
      dummy = model_write(a, wbuf[b], 4'hF);
      a = next_addr(a, 2'b01);
    end
    s_axi_wdata = wbuf[5]; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 64'd0);
    check("midrst_data", 64'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), 64'd0);
    s_axi_wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_bvalid", 64'(s_axi_bvalid), 64'd0);
    axi_read(32'h1010, 0, 2'b01, 0, "post_rst_rd4", lat, rd);
    check("post_rst_beat4", 64'(rd), 64'(wbuf[4]));
    axi_read(32'h1014, 0, 2'b01, 0, "post_rst_rd5", lat, rd);
    check("post_rst_latency", 64'(lat), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
